// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - status-flag register, branch-condition evaluation and flag save/restore stack
module alu_flags #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_a,
  input  logic [7:0]    i_b,
  input  logic          i_sub,
  input  logic [1:0]    i_aluOp,
  input  logic          i_negative,
  input  logic          i_zero,
  input  logic          i_flagsWr,
  input  logic          i_flagsPush,
  input  logic          i_flagsPop,
  input  logic [2:0]    i_cond,
  output logic [3:0]    o_flags,
  output logic          o_condTrue,
  output logic [PW-1:0] o_stackDepth,
  output logic          o_stackErr
);

  localparam logic [1:0] OP_ADDSUB = 2'b00;
  localparam logic [1:0] OP_AND    = 2'b01;
  localparam logic [1:0] OP_XOR    = 2'b10;
  localparam logic [1:0] OP_SHIFT  = 2'b11;

  logic [3:0] stack_mem [DEPTH];
  logic [7:0] b_eff;
  logic [8:0] sum9;
  logic       c_next;
  logic       v_next;
  logic [3:0] wr_flags;
  logic [3:0] stack_top;
  logic       stack_full;
  logic       stack_empty;

  // Recompute carry/overflow from the operands, then pick the flag-write value per opcode
  always_comb begin
    b_eff  = i_b ^ {8{i_sub}};
    sum9   = {1'b0, i_a} + {1'b0, b_eff} + {8'd0, i_sub};
    c_next = sum9[8];
    v_next = (i_a[7] == b_eff[7]) && (sum9[7] != i_a[7]);
    case (i_aluOp)
      OP_ADDSUB: wr_flags = {i_negative, i_zero, c_next, v_next};
      OP_AND,
      OP_XOR:    wr_flags = {i_negative, i_zero, 2'b00};
      OP_SHIFT:  wr_flags = {i_negative, i_zero, o_flags[1:0]};
      default:   wr_flags = o_flags;
    endcase
  end

  // Select the top-of-stack entry without indexing the array by the wider depth counter
  always_comb begin
    stack_top = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i + 1) == o_stackDepth) stack_top = stack_mem[i];
    end
    stack_full  = (o_stackDepth == PW'(DEPTH));
    stack_empty = (o_stackDepth == '0);
  end

  // Branch condition evaluated only on the architectural flags
  always_comb begin
    case (i_cond)
      3'b000:  o_condTrue = 1'b1;
      3'b001:  o_condTrue = o_flags[2];
      3'b010:  o_condTrue = !o_flags[2];
      3'b011:  o_condTrue = o_flags[1];
      3'b100:  o_condTrue = !o_flags[1];
      3'b101:  o_condTrue = o_flags[3];
      3'b110:  o_condTrue = o_flags[0];
      3'b111:  o_condTrue = o_flags[3] ^ o_flags[0];
      default: o_condTrue = 1'b0;
    endcase
  end

  // Flag register and stack: conflicting push/pop is an error, pop beats write, push saves pre-write flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_flags      <= 4'b0000;
      o_stackDepth <= '0;
      o_stackErr   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= 4'b0000;
    end else if (i_flagsPush && i_flagsPop) begin
      o_stackErr <= 1'b1;
    end else if (i_flagsPop) begin
      if (stack_empty) begin
        o_stackErr <= 1'b1;
      end else begin
        o_flags      <= stack_top;
        o_stackDepth <= o_stackDepth - PW'(1);
      end
    end else begin
      if (i_flagsPush) begin
        if (stack_full) begin
          o_stackErr <= 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i) == o_stackDepth) stack_mem[i] <= o_flags;
          end
          o_stackDepth <= o_stackDepth + PW'(1);
        end
      end
      if (i_flagsWr) o_flags <= wr_flags;
    end
  end

endmodule

// File: doc/alu_flags.md
# alu_flags

Status-flag stage directly downstream of the 8-bit ALU. Captures N/Z from the ALU and recomputes carry and overflow from the ALU operands. Holds the architectural flag register and evaluates branch conditions for the control unit. A small LIFO saves and restores flags across interrupt entry and return.

## Interface
Parameters:
- DEPTH, 4, number of flag-stack entries (≥1).
- PW, $clog2(DEPTH+1), width of the stack-depth output.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_a  in  8  ALU A operand, as presented to the ALU.
- i_b  in  8  ALU registered B operand, un-inverted.
- i_sub  in  1  ALU subtract control.
- i_aluOp  in  2  ALU opcode: 00 add/sub, 01 and, 10 xor, 11 shift.
- i_negative  in  1  ALU negative output.
- i_zero  in  1  ALU zero output.
- i_flagsWr  in  1  update flags from the current ALU result.
- i_flagsPush  in  1  push current flags onto the stack.
- i_flagsPop  in  1  pop the stack into the flags.
- i_cond  in  3  branch condition select.
- o_flags  out  4  registered flags {N,Z,C,V}.
- o_condTrue  out  1  selected condition is true on o_flags.
- o_stackDepth  out  PW  number of valid stack entries.
- o_stackErr  out  1  sticky stack overflow/underflow/conflict error.

## Operation
- Arithmetic, computed at 9 bits:
  - b' = i_b XOR {8{i_sub}}.
  - sum9 = {0,i_a} + {0,b'} + i_sub.
  - Cnext = sum9[8]. For subtract, C=1 means no borrow.
  - Vnext = (i_a[7] == b'[7]) && (sum9[7] != i_a[7]).
- Flag write (i_flagsWr=1), per opcode:
  - 00: N,Z taken from the ALU; C=Cnext; V=Vnext.
  - 01 and 10: N,Z taken from the ALU; C=0; V=0.
  - 11: N,Z taken from the ALU; C and V unchanged.
- Stack push: stores o_flags at index depth, then depth+1.
  - If depth==DEPTH: nothing is stored, depth is unchanged, o_stackErr is set.
- Stack pop: o_flags ← entry[depth-1], then depth-1.
  - If depth==0: flags and depth are unchanged, o_stackErr is set.
- Conditions, evaluated on o_flags only, never on in-flight values:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 V
  - 111 N XOR V (signed less-than)
- Simultaneous events:
  - Push and pop in the same cycle: both are ignored, flags and depth are unchanged, o_stackErr is set.
  - Write and push in the same cycle: the push stores the pre-write flags, and the flags take the write result.
  - Write and pop in the same cycle: pop wins and the write is dropped.
- o_stackErr clears only on reset.

## Timing
- Reset, at the next rising edge with i_reset=1:
  - o_flags=0000, o_stackDepth=0, o_stackErr=0, all stack entries cleared.
  - Reset overrides every other input in that cycle.
- Flag write, push and pop each take effect at the rising edge. Results are visible on o_flags/o_stackDepth one cycle after the strobe.
- o_condTrue is combinational from o_flags and i_cond, with zero latency from i_cond. A branch in the cycle after a flag write sees the new flags.
- i_a, i_b, i_sub, i_aluOp, i_negative and i_zero must be stable during the setup window of the edge where i_flagsWr=1. They are don't-care otherwise.
- One push or pop per cycle is supported. Back-to-back push/pop at full rate is legal.

## Test plan
- Reset, then add 0x7F+0x01 with flagsWr -> o_flags=1001 (N=1, Z=0, C=0, V=1); cond 111 -> o_condTrue=0; cond 110 -> 1.
- Sub 0x05-0x05 (i_sub=1, ALU zero=1) -> flags 0110 (Z=1, C=1); cond 001 -> 1; cond 100 -> 0.
- Sub 0x03-0x05 -> y=0xFE, flags 1000 (N=1, C=0 borrow, V=0). Then shift op with flagsWr -> C/V stay 00.
- Push 4 distinct flag values, then a 5th push -> depth stays 4, o_stackErr=1. Pop 4 times -> flags restored in reverse order, depth=0. A further pop -> flags unchanged.
- Flags=0110, assert flagsWr (add 0x80+0x80) and push together -> stack top=0110, o_flags=0111 (Z=1, C=1, V=1). Then pop with flagsWr -> o_flags=0110.
- Assert reset mid-sequence with depth=2 and err=1, while also asserting push and flagsWr -> next cycle flags=0000, depth=0, err=0.
